// File: rtl/mips_bus_arbiter_if.sv
// Bus bundle for the MIPS memory arbiter: fetch port (m0), data port (m1) and the shared RAM slave.
// The arbiter takes the slave modport; the CPU side and the RAM model take the master modport.
interface mips_bus_arbiter_if;
    logic [31:0] m0_address;
    logic        m0_read;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;

    logic [31:0] m1_address;
    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_writedata;
    logic [3:0]  m1_byteenable;
    logic        m1_waitrequest;
    logic [31:0] m1_readdata;

    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport slave (
        input  m0_address, m0_read,
        output m0_waitrequest, m0_readdata,
        input  m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        output m1_waitrequest, m1_readdata,
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport master (
        output m0_address, m0_read,
        input  m0_waitrequest, m0_readdata,
        output m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        input  m1_waitrequest, m1_readdata,
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mips_bus_arbiter.sv
// Two-master (fetch m0, data m1) to one-slave arbiter with whole-transaction grants and a sticky stall timeout.
// Optional macro MIPS_BUS_ARB_RR_EN switches IDLE arbitration from fixed m1 priority to round-robin.
module mips_bus_arbiter #(
    parameter int WAIT_LIMIT = 1023,
    parameter int CNT_W      = 10
) (
    input  logic               clk,
    input  logic               reset,
    mips_bus_arbiter_if.slave  bus,
    output logic [1:0]         grant,
    output logic               err_timeout
);
    // One-hot state encoding, so the state register doubles as the owner vector.
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_G0   = 2'b01;
    localparam logic [1:0] S_G1   = 2'b10;

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(WAIT_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [1:0] req;
    logic [1:0] own;
    logic [1:0] mwait;
    logic       own_req;
    logic       in_grant;
    logic       leave;
    logic       pick_m1;

    assign req[0]   = bus.m0_read;
    assign req[1]   = bus.m1_read | bus.m1_write;
    assign own      = state_q;
    assign own_req  = |(req & own);
    assign in_grant = |state_q;
    // A grant ends on completion (request held, slave ready) or when the owner abandons it.
    assign leave    = in_grant & ~(own_req & bus.waitrequest);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mwait
            assign mwait[gi] = reset | ~own[gi] | bus.waitrequest;
        end
    endgenerate

    assign bus.m0_waitrequest = mwait[0];
    assign bus.m1_waitrequest = mwait[1];
    assign bus.m0_readdata    = bus.readdata;
    assign bus.m1_readdata    = bus.readdata;

`ifdef MIPS_BUS_ARB_RR_EN
    logic last_q, last_d;

    // last_q = 1 means m1 held the previous grant; on a tie the other master wins.
    assign pick_m1 = req[1] & (~req[0] | ~last_q);

    always_comb begin
        last_d = last_q;
        if (leave) begin
            last_d = state_q[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign pick_m1 = req[1];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (pick_m1) begin
                    state_d = S_G1;
                    cnt_d   = '0;
                end else if (req[0]) begin
                    state_d = S_G0;
                    cnt_d   = '0;
                end
            end
            S_G0, S_G1: begin
                if (bus.waitrequest) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    if (cnt_d == LIMIT) begin
                        err_d = 1'b1;
                    end
                end
                if (leave) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Slave-side mux; reset gates it directly so an in-flight access drops without waiting for a clock.
    always_comb begin
        bus.address    = '0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = '0;
        bus.byteenable = '0;
        if (!reset) begin
            case (state_q)
                S_G0: begin
                    bus.address    = bus.m0_address;
                    bus.read       = bus.m0_read;
                    bus.byteenable = 4'b1111;
                end
                S_G1: begin
                    bus.address    = bus.m1_address;
                    bus.read       = bus.m1_read & ~bus.m1_write;
                    bus.write      = bus.m1_write;
                    bus.writedata  = bus.m1_writedata;
                    bus.byteenable = bus.m1_byteenable;
                end
                default: ;
            endcase
        end
    end

    assign grant       = state_q;
    assign err_timeout = err_q;
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Randomized and directed bench for mips_bus_arbiter, checked every cycle against a transaction-level model.
module tb_mips_bus_arbiter;
    localparam int WL = 8;
    localparam int CW = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] grant;
    logic       err_timeout;

    mips_bus_arbiter_if bus();

    mips_bus_arbiter #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .grant       (grant),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: owner is -1 (none), 0 (fetch) or 1 (data); stalls counts stalled cycles of the current grant.
    int m_owner  = -1;
    int m_stalls = 0;
    int m_last   = 0;
    int m_txn    = 0;
    bit m_err    = 1'b0;
    bit r0, r1, oreq;

    logic [1:0] rr_exp [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner  = -1;
            m_stalls = 0;
            m_err    = 1'b0;
            m_last   = 0;
        end else if (m_owner < 0) begin
            r0 = bus.m0_read;
            r1 = bus.m1_read | bus.m1_write;
            if (r0 && r1) begin
`ifdef MIPS_BUS_ARB_RR_EN
                m_owner = 1 - m_last;
`else
                m_owner = 1;
`endif
            end else if (r1) begin
                m_owner = 1;
            end else if (r0) begin
                m_owner = 0;
            end
            if (m_owner >= 0) m_stalls = 0;
        end else begin
            oreq = (m_owner == 0) ? bus.m0_read : (bus.m1_read | bus.m1_write);
            if (bus.waitrequest) begin
                if (m_stalls < (1 << CW) - 1) m_stalls++;
                if (m_stalls >= WL) m_err = 1'b1;
            end
            if (!oreq || !bus.waitrequest) begin
                m_txn++;
                $display("txn %0d: m%0d %s stalls=%0d addr=%h", m_txn, m_owner,
                         oreq ? "done" : "abandoned", m_stalls, bus.address);
                m_last  = m_owner;
                m_owner = -1;
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic [1:0]  eg;
        logic        er, ew, e0w, e1w;
        logic [31:0] ea, ewd;
        logic [3:0]  ebe;
        eg = 2'b00; er = 1'b0; ew = 1'b0; e0w = 1'b1; e1w = 1'b1;
        ea = '0; ewd = '0; ebe = '0;
        if (m_owner == 0) begin
            eg = 2'b01; er = bus.m0_read; e0w = bus.waitrequest;
            ea = bus.m0_address; ebe = 4'b1111;
        end else if (m_owner == 1) begin
            eg = 2'b10; er = bus.m1_read & ~bus.m1_write; ew = bus.m1_write;
            e1w = bus.waitrequest; ea = bus.m1_address; ewd = bus.m1_writedata;
            ebe = bus.m1_byteenable;
        end
        chk("grant", 32'(grant), 32'(eg));
        chk("read", 32'(bus.read), 32'(er));
        chk("write", 32'(bus.write), 32'(ew));
        chk("m0_waitrequest", 32'(bus.m0_waitrequest), 32'(e0w));
        chk("m1_waitrequest", 32'(bus.m1_waitrequest), 32'(e1w));
        chk("m0_readdata", bus.m0_readdata, bus.readdata);
        chk("m1_readdata", bus.m1_readdata, bus.readdata);
        chk("err_timeout", 32'(err_timeout), 32'(m_err));
        if (m_owner >= 0 || reset) begin
            chk("address", bus.address, ea);
            chk("writedata", bus.writedata, ewd);
            chk("byteenable", 32'(bus.byteenable), 32'(ebe));
        end
    end

    task automatic drive_idle();
        bus.m0_address    = '0;
        bus.m0_read       = 1'b0;
        bus.m1_address    = '0;
        bus.m1_read       = 1'b0;
        bus.m1_write      = 1'b0;
        bus.m1_writedata  = '0;
        bus.m1_byteenable = '0;
        bus.waitrequest   = 1'b0;
        bus.readdata      = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        drive_idle();
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        rr_exp = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        drive_idle();
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_m0_wait", 32'(bus.m0_waitrequest), 32'h1);
        chk("rst_m1_wait", 32'(bus.m1_waitrequest), 32'h1);
        chk("rst_byteenable", 32'(bus.byteenable), 32'h0);
        next_cycle();
        reset = 1'b0;

        // Random traffic with sticky requests so both completions and abandons occur.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3) == 0) bus.m0_read = ~bus.m0_read;
            if ($urandom_range(3) == 0) begin
                bus.m1_read  = 1'($urandom_range(1));
                bus.m1_write = 1'($urandom_range(1));
            end
            bus.m0_address    = $urandom;
            bus.m1_address    = $urandom;
            bus.m1_writedata  = $urandom;
            bus.m1_byteenable = 4'($urandom_range(15));
            bus.waitrequest   = 1'($urandom_range(1));
            bus.readdata      = $urandom;
            next_cycle();
        end
        reset_pulse();

        // Timeout: 20 stalled cycles under G1.
        bus.m1_read = 1'b1; bus.m1_address = 32'h0000_2000; bus.waitrequest = 1'b1;
        @(negedge clk); chk("to_idle_grant", 32'(grant), 32'h0);
        next_cycle();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("to_grant", 32'(grant), 32'h2);
            if (k == 8) chk("to_err_before", 32'(err_timeout), 32'h0);
            if (k == 9) chk("to_err_after", 32'(err_timeout), 32'h1);
            next_cycle();
        end
        bus.waitrequest = 1'b0; bus.readdata = 32'h1234_5678;
        @(negedge clk);
        chk("to_done_wait", 32'(bus.m1_waitrequest), 32'h0);
        chk("to_done_data", bus.m1_readdata, 32'h1234_5678);
        next_cycle();
        bus.m1_read = 1'b0;
        @(negedge clk);
        chk("to_grant_end", 32'(grant), 32'h0);
        chk("to_err_sticky", 32'(err_timeout), 32'h1);
        next_cycle();

        // Reset in the middle of a stalled G1 write.
        bus.m1_write = 1'b1; bus.m1_address = 32'h0000_0040; bus.waitrequest = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("rmid_write_before", 32'(bus.write), 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("rmid_write", 32'(bus.write), 32'h0);
        chk("rmid_grant", 32'(grant), 32'h0);
        chk("rmid_m1_wait", 32'(bus.m1_waitrequest), 32'h1);
        chk("rmid_address", bus.address, 32'h0);
        next_cycle();
        reset = 1'b0;
        drive_idle();
        @(negedge clk);
        chk("rmid_err", 32'(err_timeout), 32'h0);
        next_cycle();

        // Single fetch, ready on the second granted cycle.
        bus.m0_read = 1'b1; bus.m0_address = 32'hBFC0_0000; bus.waitrequest = 1'b1;
        @(negedge clk);
        chk("f_grant0", 32'(grant), 32'h0);
        chk("f_wait0", 32'(bus.m0_waitrequest), 32'h1);
        next_cycle();
        @(negedge clk);
        chk("f_grant1", 32'(grant), 32'h1);
        chk("f_wait1", 32'(bus.m0_waitrequest), 32'h1);
        chk("f_address", bus.address, 32'hBFC0_0000);
        next_cycle();
        bus.waitrequest = 1'b0; bus.readdata = 32'h3C02_DEAD;
        @(negedge clk);
        chk("f_wait2", 32'(bus.m0_waitrequest), 32'h0);
        chk("f_readdata", bus.m0_readdata, 32'h3C02_DEAD);
        next_cycle();
        bus.m0_read = 1'b0;
        @(negedge clk);
        chk("f_grant_end", 32'(grant), 32'h0);
        next_cycle();

        // Collision: data write wins, fetch follows after one idle cycle.
        bus.m0_read = 1'b1; bus.m0_address = 32'h0000_0100;
        bus.m1_write = 1'b1; bus.m1_address = 32'h0000_1000;
        bus.m1_writedata = 32'hDEAD_0000; bus.m1_byteenable = 4'b1100;
        @(negedge clk); chk("c_grant0", 32'(grant), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("c_grant1", 32'(grant), 32'h2);
        chk("c_write", 32'(bus.write), 32'h1);
        chk("c_byteenable", 32'(bus.byteenable), 32'hC);
        chk("c_m0_wait", 32'(bus.m0_waitrequest), 32'h1);
        next_cycle();
        bus.m1_write = 1'b0;
        @(negedge clk);
        chk("c_grant_idle", 32'(grant), 32'h0);
        chk("c_m0_wait_idle", 32'(bus.m0_waitrequest), 32'h1);
        next_cycle();
        @(negedge clk); chk("c_grant_m0", 32'(grant), 32'h1);
        next_cycle();
        bus.m0_read = 1'b0;
        next_cycle();

        // Abandon: m1 drops its read while stalled; pending fetch is granted after the idle cycle.
        bus.m1_read = 1'b1; bus.waitrequest = 1'b1;
        next_cycle();
        bus.m0_read = 1'b1;
        @(negedge clk); chk("a_grant1", 32'(grant), 32'h2);
        next_cycle();
        bus.m1_read = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("a_grant_idle", 32'(grant), 32'h0);
        chk("a_err", 32'(err_timeout), 32'h0);
        next_cycle();
        @(negedge clk); chk("a_grant_m0", 32'(grant), 32'h1);
        bus.waitrequest = 1'b0;
        next_cycle();
        bus.m0_read = 1'b0;
        next_cycle();
        next_cycle();

`ifdef MIPS_BUS_ARB_RR_EN
        // Both masters hold requests; previous owner was m0, so m1 goes first.
        bus.m0_read = 1'b1; bus.m1_read = 1'b1; bus.waitrequest = 1'b0;
        next_cycle();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_grant", 32'(grant), 32'(rr_exp[k]));
            next_cycle();
        end
        drive_idle();
        next_cycle();
`endif

        drive_idle();
        repeat (2) next_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
